lcd_cmd_sequencer: RTL

Parametrised command/data byte sequencer for an SPI/8080-style TFT controller (ST7789/ILI9341 command set).
- On request, it either runs the panel power-up sequence or fills one grid cell with a palette colour.
- It emits a stream of bytes tagged with D/CX through a valid/ready handshake to the bus driver, and inserts programmable delays after reset-class commands.
- It sits between the game/grid update FSM and the physical bus driver, and generalises grid geometry, delays and palette.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_cmd_sequencer_if.sv | 27 ++
 rtl/lcd_delay_timer.sv | 33 +++
 rtl/lcd_cmd_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, state codes and panel command bytes for the LCD sequencer
package lcd_pkg;

  typedef enum logic {OP_INIT = 1'b0, OP_CELL = 1'b1} op_e;

  typedef logic [15:0] rgb565_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ARG    = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_PIXEL  = 3'd4;
  localparam state_t ST_FINISH = 3'd5;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] COLMOD_565  = 8'h55;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // Command byte for step idx of the given operation.
  function automatic logic [7:0] cmd_byte(op_e op, logic [1:0] idx);
    logic [7:0] b;
    if (op == OP_INIT) begin
      case (idx)
        2'd0:    b = CMD_SWRESET;
        2'd1:    b = CMD_SLPOUT;
        2'd2:    b = CMD_COLMOD;
        default: b = CMD_DISPON;
      endcase
    end else begin
      case (idx)
        2'd0:    b = CMD_CASET;
        2'd1:    b = CMD_RASET;
        default: b = CMD_RAMWR;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// rtl/lcd_cmd_sequencer_if.sv - request and byte-stream bundle of the LCD sequencer
// master: sequencer side (drives req_ready, out_*, busy, done)
// slave : requester / bus-driver side (drives req_*, cell_*, obj_code, out_ready)
interface lcd_cmd_sequencer_if #(parameter int GRID_W = 4);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [GRID_W-1:0] cell_x;
  logic [GRID_W-1:0] cell_y;
  logic [2:0]        obj_code;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_dcx;
  logic              busy;
  logic              done;

  modport master (
    input  req_valid, req_op, cell_x, cell_y, obj_code, out_ready,
    output req_ready, out_valid, out_data, out_dcx, busy, done
  );

  modport slave (
    output req_valid, req_op, cell_x, cell_y, obj_code, out_ready,
    input  req_ready, out_valid, out_data, out_dcx, busy, done
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter timing the post-command waits
// clk, rst : clock, asynchronous active-high reset
// start    : load the delay (counting begins next cycle)
// expired  : counter is at zero
module lcd_delay_timer #(
  parameter int DELAY_CYC = 50000,
  parameter int DELAY_W   = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  logic [DELAY_W-1:0] cnt_q, cnt_d;

  // Loading DELAY_CYC-1 makes expired rise on the DELAY_CYC-th cycle after start.
  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = DELAY_W'(DELAY_CYC - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - DELAY_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - emits panel init or grid-cell fill byte streams tagged with D/CX
// clk, rst : clock, asynchronous active-high reset
// bus      : request handshake (req_*, cell_x/y, obj_code), byte stream (out_*), busy, done
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int CELL_W    = 20,
  parameter int CELL_H    = 20,
  parameter int GRID_W    = 4,
  parameter int DELAY_CYC = 50000,
  parameter int DELAY_W   = 17,
  parameter rgb565_t [0:7] PALETTE = {16'hFFFF, 16'h901E, 16'h6815, 16'hF800,
                                      16'h0814, 16'hFFFF, 16'hFFFF, 16'hFFFF}
) (
  input  logic clk,
  input  logic rst,
  lcd_cmd_sequencer_if.master bus
);

  localparam int PIX_TOTAL = 2 * CELL_W * CELL_H;
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);

  state_t            state_q, state_d;
  op_e               op_q, op_d;
  logic [GRID_W-1:0] cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  rgb565_t           colour_q, colour_d;
  logic [1:0]        seq_idx_q, seq_idx_d;
  logic [1:0]        arg_idx_q, arg_idx_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;

  logic        req_ready, out_valid, out_dcx, fire;
  logic        timer_start, timer_expired;
  logic [7:0]  out_data;
  logic [15:0] sc, ec, sp, ep;
  logic [31:0] coord, coord_sh;

  lcd_delay_timer #(.DELAY_CYC(DELAY_CYC), .DELAY_W(DELAY_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .expired (timer_expired)
  );

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_CMD) || (state_q == ST_ARG) || (state_q == ST_PIXEL);
  assign out_dcx   = (state_q == ST_ARG) || (state_q == ST_PIXEL);
  assign fire      = out_valid && bus.out_ready;

  // Window coordinates are derived from the latched indices, so the byte on
  // the bus depends only on registered state and stays put while stalled.
  always_comb begin
    sc       = 16'(32'(cell_x_q) * 32'(CELL_W));
    ec       = sc + 16'(CELL_W - 1);
    sp       = 16'(32'(cell_y_q) * 32'(CELL_H));
    ep       = sp + 16'(CELL_H - 1);
    coord    = (seq_idx_q == 2'd0) ? {sc, ec} : {sp, ep};
    coord_sh = coord << {arg_idx_q, 3'b000};
    case (state_q)
      ST_CMD:   out_data = cmd_byte(op_q, seq_idx_q);
      ST_ARG:   out_data = (op_q == OP_INIT) ? COLMOD_565 : coord_sh[31:24];
      ST_PIXEL: out_data = pix_cnt_q[0] ? colour_q[7:0] : colour_q[15:8];
      default:  out_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cell_x_d    = cell_x_q;
    cell_y_d    = cell_y_q;
    colour_d    = colour_q;
    seq_idx_d   = seq_idx_q;
    arg_idx_d   = arg_idx_q;
    pix_cnt_d   = pix_cnt_q;
    timer_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready) begin
          op_d      = op_e'(bus.req_op);
          cell_x_d  = bus.cell_x;
          cell_y_d  = bus.cell_y;
          colour_d  = PALETTE[bus.obj_code];
          seq_idx_d = 2'd0;
          arg_idx_d = 2'd0;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (fire) begin
          arg_idx_d = 2'd0;
          if (op_q == OP_INIT) begin
            // SWRESET and SLPOUT are followed by a settle delay.
            if (seq_idx_q < 2'd2) begin
              state_d     = ST_WAIT;
              timer_start = 1'b1;
            end else if (seq_idx_q == 2'd2) begin
              state_d = ST_ARG;
            end else begin
              state_d = ST_FINISH;
            end
          end else begin
            state_d = (seq_idx_q == 2'd2) ? ST_PIXEL : ST_ARG;
          end
        end
      end
      ST_ARG: begin
        if (fire) begin
          // COLMOD has one argument; CASET/RASET have four.
          if (op_q == OP_INIT || arg_idx_q == 2'd3) begin
            seq_idx_d = seq_idx_q + 2'd1;
            state_d   = ST_CMD;
          end else begin
            arg_idx_d = arg_idx_q + 2'd1;
          end
        end
      end
      ST_WAIT: begin
        if (timer_expired) begin
          seq_idx_d = seq_idx_q + 2'd1;
          state_d   = ST_CMD;
        end
      end
      ST_PIXEL: begin
        if (fire) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(PIX_TOTAL - 1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        seq_idx_d = 2'd0;
        arg_idx_d = 2'd0;
        pix_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_INIT;
      cell_x_q  <= '0;
      cell_y_q  <= '0;
      colour_q  <= '0;
      seq_idx_q <= '0;
      arg_idx_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cell_x_q  <= cell_x_d;
      cell_y_q  <= cell_y_d;
      colour_q  <= colour_d;
      seq_idx_q <= seq_idx_d;
      arg_idx_q <= arg_idx_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_dcx   = out_dcx;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FINISH);

endmodule
